seq_rightshift: RTL and testbench

Multi-cycle 32-bit right shifter. Complements the existing left-shift stages and covers the right-shift direction for the ALU's SRA/SRL operations. Applies the 16/8/4/2/1 shift stages one per clock, gated by the shift-amount bits, to keep the combinational path short. It uses a start/busy/done handshake so the processor's multicycle control can stall on it the same way it stalls on mult/div.

---
 rtl/seq_rightshift_pkg.sv | 17 +
 rtl/seq_rightshift_if.sv | 23 ++
 rtl/seq_rightshift_rshift_stage.sv | 15 +
 rtl/seq_rightshift.sv | 86 ++++++++
 tb/tb_seq_rightshift.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/seq_rightshift_pkg.sv
// Shared defaults, state encoding and stage-amount lookup for the multi-cycle right shifter.
package seq_rightshift_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SHAMT_W = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Stage k shifts by the largest remaining power of two: 16, 8, 4, 2, 1 for a 5-bit shamt.
   function automatic int stage_amt(input int shamt_w, input int k);
      return 1 << (shamt_w - 1 - k);
   endfunction

endpackage

// File: rtl/seq_rightshift_if.sv
// Request/result bundle between the multicycle controller and the right shifter.
interface seq_rightshift_if;
   import seq_rightshift_pkg::*;

   logic                   start;
   logic [DEF_WIDTH-1:0]   A;
   logic [DEF_SHAMT_W-1:0] shamt;
   logic                   arith;
   logic [DEF_WIDTH-1:0]   out;
   logic                   busy;
   logic                   done;

   modport master (
      output start, A, shamt, arith,
      input  out, busy, done
   );

   modport slave (
      input  start, A, shamt, arith,
      output out, busy, done
   );

endinterface

// File: rtl/seq_rightshift_rshift_stage.sv
// One constant-distance right-shift stage with fill bit; passes data through when en is low.
// Purely combinational, no state, no backpressure.
module rshift_stage #(
   parameter int WIDTH = 32,
   parameter int AMT   = 1
) (
   input  logic [WIDTH-1:0] din,
   input  logic             fill,
   input  logic             en,
   output logic [WIDTH-1:0] dout
);

   assign dout = en ? {{AMT{fill}}, din[WIDTH-1:AMT]} : din;

endmodule

// File: rtl/seq_rightshift.sv
// Multi-cycle SRA/SRL: one power-of-two stage per clock, result and done pulse 5 cycles after accept.
// No queueing: start is only sampled while idle, busy tells the controller to stall.
module seq_rightshift
   import seq_rightshift_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic              clock,
   input  logic              reset,
   seq_rightshift_if.slave   bus
);

   localparam int CNT_W = $clog2(SHAMT_W);
   localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

   state_t             state;
   logic [CNT_W-1:0]   stage;
   logic [WIDTH-1:0]   work;
   logic [SHAMT_W-1:0] shamt_q;
   logic               fill_q;
   logic [WIDTH-1:0]   stage_out [SHAMT_W];
   logic [WIDTH-1:0]   stage_sel;

   // All stages see the working register; only the one named by the counter is used.
   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      rshift_stage #(
         .WIDTH (WIDTH),
         .AMT   (stage_amt(SHAMT_W, k))
      ) u_stage (
         .din  (work),
         .fill (fill_q),
         .en   (shamt_q[SHAMT_W-1-k]),
         .dout (stage_out[k])
      );
   end

   always_comb begin
      stage_sel = work;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (stage == CNT_W'(k)) begin
            stage_sel = stage_out[k];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         stage    <= '0;
         work     <= '0;
         shamt_q  <= '0;
         fill_q   <= 1'b0;
         bus.out  <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  work     <= bus.A;
                  shamt_q  <= bus.shamt;
                  fill_q   <= bus.arith & bus.A[WIDTH-1];
                  stage    <= '0;
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               work <= stage_sel;
               if (stage == LAST_STAGE) begin
                  bus.out  <= stage_sel;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  stage    <= '0;
                  state    <= IDLE;
               end else begin
                  stage <= stage + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_rightshift.sv
// Scoreboard bench for seq_rightshift: expected results queued at issue, checked on done.
module tb_seq_rightshift;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [31:0] hold = '0;

   typedef struct {
      logic [31:0] val;
      int          e0;
   } exp_t;
   exp_t sb[$];

   seq_rightshift_if bus ();

   seq_rightshift dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh, input logic ar);
      if (ar) return 32'($signed(a) >>> sh);
      return a >> sh;
   endfunction

   // Monitor: pops on done, otherwise out must hold the last completed result.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         hold = '0;
      end else if (bus.done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("result", bus.out, e.val);
            check("latency", 32'(cyc - e.e0), 32'd5);
            hold = e.val;
         end
      end else begin
         check("out_hold", bus.out, hold);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called at a negedge; the following posedge is the accept edge.
   task automatic issue(input logic [31:0] a, input logic [4:0] sh, input logic ar, input logic [31:0] expv);
      bus.start = 1'b1;
      bus.A     = a;
      bus.shamt = sh;
      bus.arith = ar;
      sb.push_back('{expv, cyc + 1});
      @(negedge clock);
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.shamt = ~sh;
      bus.arith = ~ar;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                         input logic [31:0] expv, input bit intrude);
      int n;
      issue(a, sh, ar, expv);
      n = 0;
      while (bus.busy && n < 20) begin
         n++;
         if (intrude && n == 2) begin
            bus.start = 1'b1;
            bus.A     = 32'hFFFF_FFFF;
            bus.shamt = 5'd1;
            bus.arith = 1'b0;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clock);
      end
      bus.start = 1'b0;
      check("busy_cycles", 32'(n), 32'd5);
      check("done_pulse", 32'(bus.done), 32'd1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rr;

      bus.start = 1'b0;
      bus.A     = '0;
      bus.shamt = '0;
      bus.arith = 1'b0;

      idle(3);
      check("rst_out", bus.out, 32'h0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);

      // Reset and start together: reset wins.
      bus.start = 1'b1;
      bus.A     = 32'h1234_5678;
      @(negedge clock);
      reset     = 1'b0;
      bus.start = 1'b0;
      check("rst_vs_start_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      check("rst_vs_start_busy2", 32'(bus.busy), 32'd0);

      run_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);
      idle(2);
      run_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0);
      idle(2);
      run_op(32'h1234_5678, 5'd16, 1'b0, 32'h0000_1234, 1'b0);
      run_op(32'hF000_0000, 5'd4, 1'b1, 32'hFF00_0000, 1'b0);
      idle(2);
      run_op(32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      idle(2);

      // Start while busy must be ignored.
      run_op(32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 1'b1);
      idle(8);
      check("busy_after_ignored", 32'(bus.busy), 32'd0);

      // Reset at E3 aborts the op with no done.
      issue(32'h0000_0055, 5'd2, 1'b0, 32'h0000_0015);
      idle(2);
      reset = 1'b1;
      sb.delete();
      @(negedge clock);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_out", bus.out, 32'h0);
      reset = 1'b0;
      idle(8);
      run_op(32'h0000_0040, 5'd3, 1'b0, 32'h0000_0008, 1'b0);

      // Random back-to-back ops against the reference model.
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rs = 5'($urandom_range(0, 31));
         rr = 1'($urandom_range(0, 1));
         run_op(ra, rs, rr, model(ra, rs, rr), 1'b0);
      end
      idle(4);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
